alarm_bank: RTL and testbench
=============================

// Module: alarm_bank
// PURPOSE
//  Parametrised N-channel alarm unit replacing the per-alarm FSM instances in the clock top.
//  Each channel holds a settable alarm time and runs its own ARMED/RINGING/SNOOZED FSM against
//  the time-of-day from the clock FSM. Snooze is limited per ring. Ringing silences itself after a timeout.
//  A channel-select readback drives the BCD/7-seg display path.
// PARAMETERS
//  NUM_ALARMS        2   number of alarm channels (1..8)
//  HOURS_24          0   0: 12h hours 1..12, reset value 12; 1: 24h hours 0..23, reset value 0
//  SNOOZE_MIN        5   minutes added to current time on snooze (1..59)
//  MAX_SNOOZE        3   snoozes allowed per ring episode; further snooze_pi ignored
//  RING_TIMEOUT_MIN  10  minute rollovers spent RINGING before auto-return to ARMED (1..63)
// PORTS
//  clk_pi             in   1            system clock
//  rst_pi             in   1            synchronous reset, active-high
//  clock_minutes_pi   in   6            current minutes 0..59
//  clock_hours_pi     in   5            current hours (range per HOURS_24)
//  en_pi              in   NUM_ALARMS   per-channel enable (level)
//  sel_pi             in   SEL_W        channel for edit/readback; SEL_W = max(1,clog2(NUM_ALARMS))
//  inc_minute_pi      in   1            one-cycle pulse: increment minutes of sel_pi channel
//  inc_hour_pi        in   1            one-cycle pulse: increment hours of sel_pi channel
//  snooze_pi          in   1            one-cycle pulse: snooze every RINGING channel
//  dismiss_pi         in   1            one-cycle pulse: dismiss every RINGING/SNOOZED channel
//  sel_minutes_po     out  6            alarm minutes of sel_pi channel (combinational)
//  sel_hours_po       out  5            alarm hours of sel_pi channel (combinational)
//  ringing_po         out  NUM_ALARMS   registered, 1 while channel RINGING
//  snoozed_po         out  NUM_ALARMS   registered, 1 while channel SNOOZED
//  any_ringing_po     out  1            OR of ringing_po
// BEHAVIOUR
//  - Reset: all alarm times 12:00 (HOURS_24=0) or 00:00 (HOURS_24=1); all FSMs IDLE; ringing_po,
//    snoozed_po, any_ringing_po = 0; snooze/timeout counters 0; prev-time register <= current time.
//  - Tick: tick = ({hours,minutes} != prev_time); prev_time updated every cycle. Matching only on
//    tick cycles, so a channel fires once per minute and never re-fires after dismiss in that minute.
//  - FSM per channel: IDLE, ARMED, RINGING, SNOOZED. en_pi[i]=0 -> IDLE next cycle from any state.
//    IDLE -> ARMED when en_pi[i]=1 (no trigger in the enabling cycle).
//    ARMED -> RINGING on tick with clock time == alarm time; clears snooze count and timeout counter.
//    RINGING -> SNOOZED on snooze_pi if snooze count < MAX_SNOOZE; snooze target = current time +
//      SNOOZE_MIN, minutes wrap mod 60 with carry into hours (12->1 in 12h, 23->0 in 24h); count++.
//    RINGING -> ARMED on dismiss_pi, or on tick when timeout counter reaches RING_TIMEOUT_MIN.
//    SNOOZED -> RINGING on tick with clock time == snooze target (timeout counter cleared, count kept).
//    SNOOZED -> ARMED on dismiss_pi.
//  - Priority per cycle: rst_pi > en_pi=0 > dismiss_pi > snooze_pi > match/timeout.
//  - Latency: ringing_po rises the cycle after the tick cycle; falls the cycle after dismiss/snooze.
//  - Edit: inc_minute_pi 59->0, no carry into hours; inc_hour_pi 12->1 (12h) / 23->0 (24h).
//    Both pulses in one cycle apply both. Edits legal in any state, do not change FSM state or
//    active snooze target. sel_pi >= NUM_ALARMS: increments ignored, readback 0.
//  - Edit landing on current time does not fire until the next matching tick.
// CONFIGURATION
//  ALARM_BANK_SNOOZE_EN defined: snooze as above.
//  Not defined: snooze_pi ignored; SNOOZED unreachable; snoozed_po tied 0; snooze target and
//  snooze count registers not built; MAX_SNOOZE and SNOOZE_MIN unused.
// TESTING
//  1 Reset, NUM_ALARMS=2, 12h -> sel 0/1 read 12:00; ringing_po=00; snoozed_po=00.
//  2 ch0 set 6:30, en=01, clock 6:29->6:30 -> ringing_po=01 next cycle; hold 6:30 + dismiss -> no re-fire.
//  3 ch0 ringing at 11:58, snooze -> snoozed_po=01; clock to 12:03 -> ringing_po=01 (hour wrap 11->12).
//  4 Snooze 3x (MAX_SNOOZE=3), 4th snooze_pi -> stays RINGING; 10 more ticks -> ARMED, ringing_po=0.
//  5 Snooze+dismiss same cycle -> ARMED; en_pi drop during match tick -> IDLE, no ring.
//  6 HOURS_24=1: inc_hour_pi at 23 -> 0; inc_minute_pi at 59 -> 0, hours unchanged; sel_pi=3 ignored.

Source files
------------

// File: rtl/alarm_bank.sv
// alarm_bank: N-channel alarm unit, one IDLE/ARMED/RINGING/SNOOZED FSM per channel, with edit/readback.
// Snooze logic (target/count registers, SNOOZED state) is built only when ALARM_BANK_SNOOZE_EN is defined.
module alarm_bank #(
  parameter int unsigned NUM_ALARMS       = 2,
  parameter int unsigned HOURS_24         = 0,
  parameter int unsigned SNOOZE_MIN       = 5,
  parameter int unsigned MAX_SNOOZE       = 3,
  parameter int unsigned RING_TIMEOUT_MIN = 10,
  localparam int unsigned SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk_pi,
  input  logic                  rst_pi,
  input  logic [5:0]            clock_minutes_pi,
  input  logic [4:0]            clock_hours_pi,
  input  logic [NUM_ALARMS-1:0] en_pi,
  input  logic [SEL_W-1:0]      sel_pi,
  input  logic                  inc_minute_pi,
  input  logic                  inc_hour_pi,
  input  logic                  snooze_pi,
  input  logic                  dismiss_pi,
  output logic [5:0]            sel_minutes_po,
  output logic [4:0]            sel_hours_po,
  output logic [NUM_ALARMS-1:0] ringing_po,
  output logic [NUM_ALARMS-1:0] snoozed_po,
  output logic                  any_ringing_po
);
  localparam int unsigned MIN_W = 6;
  localparam int unsigned HR_W  = 5;
  localparam int unsigned TMO_W = 6;
  localparam logic [HR_W-1:0] HR_RST = (HOURS_24 != 0) ? 5'd0 : 5'd12;

  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZED} state_t;

  function automatic logic [HR_W-1:0] hour_inc(input logic [HR_W-1:0] h);
    if (HOURS_24 != 0) return (h >= 5'd23) ? 5'd0 : h + 5'd1;
    return (h >= 5'd12) ? 5'd1 : h + 5'd1;
  endfunction

  function automatic logic [MIN_W-1:0] minute_inc(input logic [MIN_W-1:0] m);
    return (m >= 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  state_t                state_q   [NUM_ALARMS];
  state_t                state_d   [NUM_ALARMS];
  logic [MIN_W-1:0]      alm_min_q [NUM_ALARMS];
  logic [MIN_W-1:0]      alm_min_d [NUM_ALARMS];
  logic [HR_W-1:0]       alm_hr_q  [NUM_ALARMS];
  logic [HR_W-1:0]       alm_hr_d  [NUM_ALARMS];
  logic [TMO_W-1:0]      tmo_q     [NUM_ALARMS];
  logic [TMO_W-1:0]      tmo_d     [NUM_ALARMS];
  logic [HR_W+MIN_W-1:0] prev_time_q;
  logic [HR_W+MIN_W-1:0] cur_time;
  logic                  tick;
  logic [NUM_ALARMS-1:0] ringing_d;

`ifdef ALARM_BANK_SNOOZE_EN
  localparam int unsigned SC_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  logic [SC_W-1:0]       snz_cnt_q [NUM_ALARMS];
  logic [SC_W-1:0]       snz_cnt_d [NUM_ALARMS];
  logic [MIN_W-1:0]      snz_min_q [NUM_ALARMS];
  logic [MIN_W-1:0]      snz_min_d [NUM_ALARMS];
  logic [HR_W-1:0]       snz_hr_q  [NUM_ALARMS];
  logic [HR_W-1:0]       snz_hr_d  [NUM_ALARMS];
  logic [6:0]            snz_sum;
  logic [MIN_W-1:0]      snz_tgt_min;
  logic [HR_W-1:0]       snz_tgt_hr;
  logic [NUM_ALARMS-1:0] snoozed_d;

  // Snooze target: current time plus SNOOZE_MIN, minute overflow carries into the hour.
  always_comb begin
    snz_sum     = 7'(clock_minutes_pi) + 7'(SNOOZE_MIN);
    snz_tgt_min = 6'(snz_sum);
    snz_tgt_hr  = clock_hours_pi;
    if (snz_sum >= 7'd60) begin
      snz_tgt_min = 6'(snz_sum - 7'd60);
      snz_tgt_hr  = hour_inc(clock_hours_pi);
    end
  end
`else
  logic unused_snooze;
  assign unused_snooze = ^{snooze_pi, 6'(SNOOZE_MIN), 8'(MAX_SNOOZE)};
  assign snoozed_po    = '0;
`endif

  // Per-channel next state, edits and readback mux.
  always_comb begin
    cur_time       = {clock_hours_pi, clock_minutes_pi};
    tick           = (cur_time != prev_time_q);
    sel_minutes_po = '0;
    sel_hours_po   = '0;
    ringing_d      = '0;
`ifdef ALARM_BANK_SNOOZE_EN
    snoozed_d      = '0;
`endif
    for (int i = 0; i < NUM_ALARMS; i++) begin
      state_d[i]   = state_q[i];
      alm_min_d[i] = alm_min_q[i];
      alm_hr_d[i]  = alm_hr_q[i];
      tmo_d[i]     = tmo_q[i];
`ifdef ALARM_BANK_SNOOZE_EN
      snz_cnt_d[i] = snz_cnt_q[i];
      snz_min_d[i] = snz_min_q[i];
      snz_hr_d[i]  = snz_hr_q[i];
`endif
      if (sel_pi == SEL_W'(i)) begin
        sel_minutes_po = alm_min_q[i];
        sel_hours_po   = alm_hr_q[i];
        if (inc_minute_pi) alm_min_d[i] = minute_inc(alm_min_q[i]);
        if (inc_hour_pi)   alm_hr_d[i]  = hour_inc(alm_hr_q[i]);
      end

      if (!en_pi[i]) begin
        state_d[i] = IDLE;
      end else begin
        case (state_q[i])
          IDLE: state_d[i] = ARMED;
          ARMED: begin
            if (tick && (cur_time == {alm_hr_q[i], alm_min_q[i]})) begin
              state_d[i] = RINGING;
              tmo_d[i]   = '0;
`ifdef ALARM_BANK_SNOOZE_EN
              snz_cnt_d[i] = '0;
`endif
            end
          end
          RINGING: begin
            if (dismiss_pi) begin
              state_d[i] = ARMED;
            end
`ifdef ALARM_BANK_SNOOZE_EN
            else if (snooze_pi && (snz_cnt_q[i] < SC_W'(MAX_SNOOZE))) begin
              state_d[i]   = SNOOZED;
              snz_min_d[i] = snz_tgt_min;
              snz_hr_d[i]  = snz_tgt_hr;
              snz_cnt_d[i] = snz_cnt_q[i] + SC_W'(1);
            end
`endif
            else if (tick) begin
              // The counter holds completed rollovers; the last one returns to ARMED.
              if (tmo_q[i] >= TMO_W'(RING_TIMEOUT_MIN - 1)) state_d[i] = ARMED;
              else tmo_d[i] = tmo_q[i] + TMO_W'(1);
            end
          end
`ifdef ALARM_BANK_SNOOZE_EN
          SNOOZED: begin
            if (dismiss_pi) begin
              state_d[i] = ARMED;
            end else if (tick && (cur_time == {snz_hr_q[i], snz_min_q[i]})) begin
              state_d[i] = RINGING;
              tmo_d[i]   = '0;
            end
          end
`endif
          default: state_d[i] = IDLE;
        endcase
      end

      ringing_d[i] = (state_d[i] == RINGING);
`ifdef ALARM_BANK_SNOOZE_EN
      snoozed_d[i] = (state_d[i] == SNOOZED);
`endif
    end
  end

  // State and registered status outputs.
  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      prev_time_q    <= {clock_hours_pi, clock_minutes_pi};
      ringing_po     <= '0;
      any_ringing_po <= 1'b0;
`ifdef ALARM_BANK_SNOOZE_EN
      snoozed_po     <= '0;
`endif
      for (int i = 0; i < NUM_ALARMS; i++) begin
        state_q[i]   <= IDLE;
        alm_min_q[i] <= '0;
        alm_hr_q[i]  <= HR_RST;
        tmo_q[i]     <= '0;
`ifdef ALARM_BANK_SNOOZE_EN
        snz_cnt_q[i] <= '0;
        snz_min_q[i] <= '0;
        snz_hr_q[i]  <= '0;
`endif
      end
    end else begin
      prev_time_q    <= cur_time;
      state_q        <= state_d;
      alm_min_q      <= alm_min_d;
      alm_hr_q       <= alm_hr_d;
      tmo_q          <= tmo_d;
      ringing_po     <= ringing_d;
      any_ringing_po <= |ringing_d;
`ifdef ALARM_BANK_SNOOZE_EN
      snz_cnt_q      <= snz_cnt_d;
      snz_min_q      <= snz_min_d;
      snz_hr_q       <= snz_hr_d;
      snoozed_po     <= snoozed_d;
`endif
    end
  end

endmodule

// File: tb/tb_alarm_bank.sv
// tb_alarm_bank: self-checking bench for alarm_bank (12h, 2 channels) plus a 24h, 3-channel edit-path instance.
`timescale 1ns/1ps
module tb_alarm_bank;
  localparam int N       = 2;
  localparam int DIAL    = 720;
  localparam int SNZ_MIN = 5;
  localparam int MAX_SNZ = 3;
  localparam int TMO     = 10;
`ifdef ALARM_BANK_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif
  localparam int S_IDLE = 0, S_ARMED = 1, S_RING = 2, S_SNZ = 3;

  logic         clk;
  logic         rst;
  logic [5:0]   c_min;
  logic [4:0]   c_hr;
  logic [N-1:0] en;
  logic         sel;
  logic         inc_min, inc_hr, snooze, dismiss;
  logic [5:0]   rd_min;
  logic [4:0]   rd_hr;
  logic [N-1:0] ringing, snoozed;
  logic         any_ring;

  logic [2:0]   en24;
  logic [1:0]   sel24;
  logic         inc_min24, inc_hr24;
  logic [5:0]   rd_min24;
  logic [4:0]   rd_hr24;
  logic [2:0]   ring24, snz24;
  logic         any24;

  // Reference model state: alarm times as hour/minute, snooze targets as minutes on the 12h dial.
  int m_amin [N];
  int m_ahr  [N];
  int m_st   [N];
  int m_tmo  [N];
  int m_cnt  [N];
  int m_tgt  [N];
  int m_prev;
  int e24_min [3];
  int e24_hr  [3];
  int n_checks;
  int n_errors;

  alarm_bank dut (
    .clk_pi(clk), .rst_pi(rst), .clock_minutes_pi(c_min), .clock_hours_pi(c_hr),
    .en_pi(en), .sel_pi(sel), .inc_minute_pi(inc_min), .inc_hour_pi(inc_hr),
    .snooze_pi(snooze), .dismiss_pi(dismiss), .sel_minutes_po(rd_min), .sel_hours_po(rd_hr),
    .ringing_po(ringing), .snoozed_po(snoozed), .any_ringing_po(any_ring)
  );

  alarm_bank #(.NUM_ALARMS(3), .HOURS_24(1)) dut24 (
    .clk_pi(clk), .rst_pi(rst), .clock_minutes_pi(6'd0), .clock_hours_pi(5'd0),
    .en_pi(en24), .sel_pi(sel24), .inc_minute_pi(inc_min24), .inc_hour_pi(inc_hr24),
    .snooze_pi(1'b0), .dismiss_pi(1'b0), .sel_minutes_po(rd_min24), .sel_hours_po(rd_hr24),
    .ringing_po(ring24), .snoozed_po(snz24), .any_ringing_po(any24)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int dial(int h, int m);
    return (h % 12) * 60 + m;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_time(int h, int m);
    c_hr  = 5'(h);
    c_min = 6'(m);
  endtask

  task automatic set_dial(int idx);
    idx = ((idx % DIAL) + DIAL) % DIAL;
    set_time((idx / 60 == 0) ? 12 : idx / 60, idx % 60);
  endtask

  task automatic adv_min();
    set_dial(dial(int'(c_hr), int'(c_min)) + 1);
  endtask

  // Apply one clock of the alarm rules to the model, using the inputs currently driven.
  task automatic model_step();
    int  cur;
    bit  tick;
    cur  = dial(int'(c_hr), int'(c_min));
    tick = (cur != m_prev);
    for (int i = 0; i < N; i++) begin
      if (!en[i]) m_st[i] = S_IDLE;
      else if (m_st[i] == S_IDLE) m_st[i] = S_ARMED;
      else if (m_st[i] == S_ARMED) begin
        if (tick && cur == dial(m_ahr[i], m_amin[i])) begin
          m_st[i] = S_RING; m_tmo[i] = 0; m_cnt[i] = 0;
        end
      end else if (m_st[i] == S_RING) begin
        if (dismiss) m_st[i] = S_ARMED;
        else if (SNZ && snooze && m_cnt[i] < MAX_SNZ) begin
          m_st[i] = S_SNZ; m_tgt[i] = (cur + SNZ_MIN) % DIAL; m_cnt[i]++;
        end else if (tick) begin
          m_tmo[i]++;
          if (m_tmo[i] == TMO) m_st[i] = S_ARMED;
        end
      end else begin
        if (dismiss) m_st[i] = S_ARMED;
        else if (tick && cur == m_tgt[i]) begin m_st[i] = S_RING; m_tmo[i] = 0; end
      end
    end
    if (inc_min) m_amin[sel] = (m_amin[sel] + 1) % 60;
    if (inc_hr)  m_ahr[sel]  = m_ahr[sel] % 12 + 1;
    if (int'(sel24) < 3) begin
      if (inc_min24) e24_min[sel24] = (e24_min[sel24] + 1) % 60;
      if (inc_hr24)  e24_hr[sel24]  = (e24_hr[sel24] + 1) % 24;
    end
    m_prev = cur;
  endtask

  task automatic check_all();
    logic [N-1:0] er, es;
    int em24, eh24;
    for (int i = 0; i < N; i++) begin
      er[i] = (m_st[i] == S_RING);
      es[i] = (m_st[i] == S_SNZ);
    end
    em24 = 0; eh24 = 0;
    if (int'(sel24) < 3) begin em24 = e24_min[sel24]; eh24 = e24_hr[sel24]; end
    check("ringing", 32'(ringing), 32'(er));
    check("snoozed", 32'(snoozed), 32'(es));
    check("any_ringing", 32'(any_ring), 32'(|er));
    check("sel_minutes", 32'(rd_min), 32'(m_amin[sel]));
    check("sel_hours", 32'(rd_hr), 32'(m_ahr[sel]));
    check("sel24_minutes", 32'(rd_min24), 32'(em24));
    check("sel24_hours", 32'(rd_hr24), 32'(eh24));
    check("ringing24", 32'({any24, snz24, ring24}), 32'd0);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    inc_min = 1'b0; inc_hr = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    inc_min24 = 1'b0; inc_hr24 = 1'b0;
    check_all();
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; set_time(1, 0); en = '0; sel = 1'b0;
    inc_min = 1'b0; inc_hr = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    en24 = '0; sel24 = 2'd0; inc_min24 = 1'b0; inc_hr24 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_amin[i] = 0; m_ahr[i] = 12; m_st[i] = S_IDLE; m_tmo[i] = 0; m_cnt[i] = 0; m_tgt[i] = 0;
    end
    for (int i = 0; i < 3; i++) begin e24_min[i] = 0; e24_hr[i] = 0; end
    m_prev = dial(1, 0);

    // Reset state and readback of both channels.
    check_all();
    check("t1_ch0_hr", 32'(rd_hr), 32'd12);
    check("t1_ch0_min", 32'(rd_min), 32'd0);
    sel = 1'b1; #1;
    check("t1_ch1_hr", 32'(rd_hr), 32'd12);
    check("t1_ch1_min", 32'(rd_min), 32'd0);
    check("t1_ring", 32'({snoozed, ringing}), 32'd0);
    sel = 1'b0; #1;

    // Channel 0 set to 6:30, rings once, no re-fire after dismiss in the same minute.
    repeat (6)  begin inc_hr = 1'b1;  cycle(); end
    repeat (30) begin inc_min = 1'b1; cycle(); end
    check("t2_set_hr", 32'(rd_hr), 32'd6);
    check("t2_set_min", 32'(rd_min), 32'd30);
    set_time(6, 29); cycle();
    en = 2'b01; cycle(); cycle();
    set_time(6, 30); cycle();
    check("t2_ring", 32'(ringing), 32'd1);
    dismiss = 1'b1; cycle();
    check("t2_dismiss", 32'(ringing), 32'd0);
    repeat (3) cycle();
    check("t2_no_refire", 32'(ringing), 32'd0);

    // Channel 0 to 11:58; ring, then snooze across the 11->12 hour wrap.
    repeat (5)  begin inc_hr = 1'b1;  cycle(); end
    repeat (28) begin inc_min = 1'b1; cycle(); end
    set_time(11, 57); cycle();
    set_time(11, 58); cycle();
    check("t3_ring", 32'(ringing), 32'd1);
`ifdef ALARM_BANK_SNOOZE_EN
    snooze = 1'b1; cycle();
    check("t3_snoozed", 32'({snoozed, ringing}), 32'b0100);
    repeat (4) begin adv_min(); cycle(); end
    check("t3_still_snoozed", 32'(snoozed), 32'd1);
    adv_min(); cycle();
    check("t3_wrap_ring", 32'({snoozed, ringing}), 32'b0001);
    repeat (2) begin
      snooze = 1'b1; cycle();
      repeat (5) begin adv_min(); cycle(); end
    end
    check("t4_third_ring", 32'(ringing), 32'd1);
    snooze = 1'b1; cycle();
    check("t4_limit", 32'({snoozed, ringing}), 32'b0001);
`else
    snooze = 1'b1; cycle();
    check("t4_snooze_ignored", 32'({snoozed, ringing}), 32'b0001);
`endif
    repeat (TMO - 1) begin adv_min(); cycle(); end
    check("t4_pre_timeout", 32'(ringing), 32'd1);
    adv_min(); cycle();
    check("t4_timeout", 32'(ringing), 32'd0);

    // Snooze and dismiss together, then enable dropped on the matching tick.
    set_time(11, 57); cycle();
    set_time(11, 58); cycle();
    check("t5_ring", 32'(ringing), 32'd1);
    snooze = 1'b1; dismiss = 1'b1; cycle();
    check("t5_snz_dis", 32'({snoozed, ringing}), 32'd0);
    set_time(11, 57); cycle();
    set_time(11, 58); en = 2'b00; cycle();
    check("t5_en_drop", 32'(ringing), 32'd0);
    en = 2'b01; cycle(); cycle();
    check("t5_no_late_fire", 32'(ringing), 32'd0);

    // Editing channel 1 onto the current time waits for the next matching tick.
    en = 2'b11; set_time(12, 1); cycle();
    sel = 1'b1; inc_min = 1'b1; cycle();
    check("t_edit_min", 32'(rd_min), 32'd1);
    repeat (3) cycle();
    check("t_edit_no_fire", 32'(ringing), 32'd0);
    set_time(12, 2); cycle();
    set_time(12, 1); cycle();
    check("t_edit_fire", 32'(ringing), 32'b10);
    dismiss = 1'b1; cycle();
    sel = 1'b0; #1;

    // 24h instance: hour and minute wrap, out-of-range select.
    repeat (23) begin inc_hr24 = 1'b1; cycle(); end
    check("t6_hr23", 32'(rd_hr24), 32'd23);
    inc_hr24 = 1'b1; cycle();
    check("t6_hr_wrap", 32'(rd_hr24), 32'd0);
    repeat (5)  begin inc_hr24 = 1'b1;  cycle(); end
    repeat (59) begin inc_min24 = 1'b1; cycle(); end
    check("t6_min59", 32'(rd_min24), 32'd59);
    inc_min24 = 1'b1; cycle();
    check("t6_min_wrap", 32'({rd_hr24, rd_min24}), 32'({5'd5, 6'd0}));
    sel24 = 2'd3; #1;
    check("t6_sel3_read", 32'({rd_hr24, rd_min24}), 32'd0);
    inc_min24 = 1'b1; inc_hr24 = 1'b1; cycle();
    sel24 = 2'd0; #1;
    check("t6_sel3_ignored", 32'({rd_hr24, rd_min24}), 32'({5'd5, 6'd0}));
    inc_min24 = 1'b1; inc_hr24 = 1'b1; cycle();
    check("t6_both", 32'({rd_hr24, rd_min24}), 32'({5'd6, 6'd1}));

    // Randomised traffic against the model.
    en = 2'b11;
    for (int k = 0; k < 800; k++) begin
      int r;
      int ch;
      r  = int'($urandom_range(0, 99));
      ch = int'($urandom_range(0, N - 1));
      if (r < 30) adv_min();
      else if (r < 38) set_dial(dial(m_ahr[ch], m_amin[ch]) - int'($urandom_range(0, 1)));
      sel     = 1'($urandom_range(0, 1));
      inc_min = ($urandom_range(0, 99) < 4);
      inc_hr  = ($urandom_range(0, 99) < 4);
      snooze  = ($urandom_range(0, 99) < 12);
      dismiss = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 4) en = 2'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
